bakery_3proc: RTL

BAKERY_3PROC -- requirements
Module: bakery_3proc

---
 rtl/bakery_pkg.sv | 17 +
 rtl/bakery_proc.sv | 71 +++++++
 rtl/bakery_3proc.sv | 98 +++++++++
 3 files changed

// File: rtl/bakery_pkg.sv
// Shared definitions for the three-process bakery lock: process-state encoding,
// process count and default ticket width.
package bakery_pkg;

    localparam int unsigned NPROC            = 3;
    localparam int unsigned TICKET_W_DEFAULT = 3;

    localparam logic [1:0] PcIdle   = 2'd0;
    localparam logic [1:0] PcChoose = 2'd1;
    localparam logic [1:0] PcWait   = 2'd2;
    localparam logic [1:0] PcCrit   = 2'd3;

    function automatic logic is_onehot(input logic [NPROC-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/bakery_proc.sv
// One bakery-lock process: pc/ticket/choosing state stepped under a scheduler
// grant. The entry guard and the maximum of the other tickets come from the top.
module bakery_proc
    import bakery_pkg::*;
#(
    parameter int unsigned TICKET_W = TICKET_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    input  logic                may_enter_i,
    input  logic [TICKET_W-1:0] max_other_i,
    output logic [1:0]          pc_o,
    output logic [TICKET_W-1:0] ticket_o,
    output logic                choosing_o
);

    localparam logic [TICKET_W-1:0] MaxT = '1;

    logic [1:0]          pc_q, pc_d;
    logic [TICKET_W-1:0] ticket_q, ticket_d;
    logic                choosing_q, choosing_d;

    always_comb begin
        pc_d       = pc_q;
        ticket_d   = ticket_q;
        choosing_d = choosing_q;
        if (step_i) begin
            case (pc_q)
                PcIdle: begin
                    pc_d       = PcChoose;
                    choosing_d = 1'b1;
                end
                PcChoose: begin
                    // A saturated maximum would wrap the ticket; keep choosing instead.
                    if (max_other_i != MaxT) begin
                        ticket_d   = max_other_i + 1'b1;
                        choosing_d = 1'b0;
                        pc_d       = PcWait;
                    end
                end
                PcWait: begin
                    if (may_enter_i) begin
                        pc_d = PcCrit;
                    end
                end
                default: begin
                    pc_d     = PcIdle;
                    ticket_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PcIdle;
            ticket_q   <= '0;
            choosing_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ticket_q   <= ticket_d;
            choosing_q <= choosing_d;
        end
    end

    assign pc_o       = pc_q;
    assign ticket_o   = ticket_q;
    assign choosing_o = choosing_q;

endmodule

// File: rtl/bakery_3proc.sv
// Three-process Lamport bakery lock with ticket-max and precedence logic.
// Optional sticky mutual-exclusion checker enabled by BAKERY_MUTEX_CHECK_EN.
module bakery_3proc
    import bakery_pkg::*;
#(
    parameter int unsigned TICKET_W = TICKET_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          select,
    input  logic                pause,
    input  logic [2:0]          sym_break,
    output logic [1:0]          pc0,
    output logic [1:0]          pc1,
    output logic [1:0]          pc2,
    output logic [TICKET_W-1:0] ticket0,
    output logic [TICKET_W-1:0] ticket1,
    output logic [TICKET_W-1:0] ticket2,
    output logic [2:0]          crit,
    output logic                mutex_err
);

    logic [1:0]          pc        [NPROC];
    logic [TICKET_W-1:0] ticket    [NPROC];
    logic [TICKET_W-1:0] max_other [NPROC];
    logic [NPROC-1:0]    choosing;
    logic [NPROC-1:0]    may_enter;
    logic [NPROC-1:0]    step;

    // True when (ta,a) is served before (tb,b).
    function automatic logic precedes(input logic [TICKET_W-1:0] ta, input logic [1:0] a,
                                      input logic [TICKET_W-1:0] tb, input logic [1:0] b,
                                      input logic [2:0] sb);
        if (ta != tb) begin
            return ta < tb;
        end
        if (is_onehot(sb) && (sb[a] || sb[b])) begin
            return sb[a];
        end
        return a < b;
    endfunction

    function automatic logic clear_of(input logic [TICKET_W-1:0] ti, input logic [1:0] i,
                                      input logic [TICKET_W-1:0] tj, input logic [1:0] j,
                                      input logic cj, input logic [2:0] sb);
        return !cj && ((tj == '0) || precedes(ti, i, tj, j, sb));
    endfunction

    assign step = (!pause && is_onehot(select)) ? select : '0;

    for (genvar g = 0; g < NPROC; g++) begin : g_proc
        localparam int unsigned J1 = (g + 1) % NPROC;
        localparam int unsigned J2 = (g + 2) % NPROC;

        assign max_other[g] = (ticket[J1] > ticket[J2]) ? ticket[J1] : ticket[J2];
        assign may_enter[g] =
            clear_of(ticket[g], 2'(g), ticket[J1], 2'(J1), choosing[J1], sym_break) &&
            clear_of(ticket[g], 2'(g), ticket[J2], 2'(J2), choosing[J2], sym_break);
        assign crit[g] = (pc[g] == PcCrit);

        bakery_proc #(
            .TICKET_W (TICKET_W)
        ) u_proc (
            .clk         (clk),
            .rst         (rst),
            .step_i      (step[g]),
            .may_enter_i (may_enter[g]),
            .max_other_i (max_other[g]),
            .pc_o        (pc[g]),
            .ticket_o    (ticket[g]),
            .choosing_o  (choosing[g])
        );
    end

    assign pc0     = pc[0];
    assign pc1     = pc[1];
    assign pc2     = pc[2];
    assign ticket0 = ticket[0];
    assign ticket1 = ticket[1];
    assign ticket2 = ticket[2];

`ifdef BAKERY_MUTEX_CHECK_EN
    logic mutex_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mutex_err_q <= 1'b0;
        end else if ((crit & (crit - 1'b1)) != '0) begin
            mutex_err_q <= 1'b1;
        end
    end

    assign mutex_err = mutex_err_q;
`else
    assign mutex_err = 1'b0;
`endif

endmodule
